// File: rtl/pe_job_sequencer.sv
// pe_job_sequencer
// Runs one reversible-PE job at a time. For each job it:
//   - streams input-buffer read addresses,
//   - gates the PE pipeline,
//   - produces output-buffer write-back strobes and addresses delayed by the fixed PE latency,
//   - counts the err1/err2 reverse-check flags,
//   - pulses done when the job ends.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   job_valid/job_ready  job handshake (accepted only in IDLE)
//   job_base, job_len_m1 first buffer address, job length minus one
//   abort                terminate the running job (ISSUE/DRAIN only)
//   rd_en, rd_addr       input-buffer read strobe and address
//   pe_en                PE pipeline enable (equals busy)
//   wb_en, wb_addr       output-buffer write strobe and address
//   err1_in, err2_in     reverse-check flags from the PE
//   err1_cnt, err2_cnt   saturating per-job flag counts
//   busy                 job in ISSUE or DRAIN
//   done                 one-cycle end-of-job pulse
//   aborted              last finished job was aborted
module pe_job_sequencer #(
    parameter int unsigned DATA_NUM = 16,
    parameter int unsigned AW       = $clog2(DATA_NUM),
    parameter int unsigned PIPE_LAT = 3,
    parameter int unsigned ECW      = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          job_valid,
    output logic          job_ready,
    input  logic [AW-1:0] job_base,
    input  logic [AW-1:0] job_len_m1,
    input  logic          abort,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    output logic          pe_en,
    output logic          wb_en,
    output logic [AW-1:0] wb_addr,
    input  logic          err1_in,
    input  logic          err2_in,
    output logic [ECW-1:0] err1_cnt,
    output logic [ECW-1:0] err2_cnt,
    output logic          busy,
    output logic          done,
    output logic          aborted
);

    typedef enum logic [1:0] {StIdle, StIssue, StDrain, StFin} state_t;

    localparam logic [ECW-1:0] ErrMax = '1;

    state_t              state;
    logic [AW-1:0]       len_m1;
    logic [AW-1:0]       issue_cnt;
    logic [PIPE_LAT-1:0] vpipe;
    logic [PIPE_LAT-1:0] vpipe_next;

    // Bit i of vpipe marks a read issued i+1 cycles ago; the MSB lines up with its result.
    always_comb begin
        vpipe_next = (vpipe << 1) | PIPE_LAT'(rd_en);
    end

    assign wb_en = vpipe[PIPE_LAT-1];
    assign pe_en = busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= StIdle;
            job_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            aborted   <= 1'b0;
            rd_en     <= 1'b0;
            rd_addr   <= '0;
            wb_addr   <= '0;
            len_m1    <= '0;
            issue_cnt <= '0;
            vpipe     <= '0;
            err1_cnt  <= '0;
            err2_cnt  <= '0;
        end else begin
            done  <= 1'b0;
            vpipe <= vpipe_next;

            if (wb_en) begin
                wb_addr <= wb_addr + 1'b1;
            end

            if (busy) begin
                if (err1_in && (err1_cnt != ErrMax)) begin
                    err1_cnt <= err1_cnt + 1'b1;
                end
                if (err2_in && (err2_cnt != ErrMax)) begin
                    err2_cnt <= err2_cnt + 1'b1;
                end
            end

            unique case (state)
                StIdle: begin
                    if (job_valid) begin
                        state     <= StIssue;
                        job_ready <= 1'b0;
                        busy      <= 1'b1;
                        rd_en     <= 1'b1;
                        rd_addr   <= job_base;
                        wb_addr   <= job_base;
                        len_m1    <= job_len_m1;
                        issue_cnt <= '0;
                        err1_cnt  <= '0;
                        err2_cnt  <= '0;
                        aborted   <= 1'b0;
                    end
                end
                StIssue: begin
                    if (abort) begin
                        state   <= StFin;
                        rd_en   <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        aborted <= 1'b1;
                        vpipe   <= '0;
                    end else begin
                        rd_addr <= rd_addr + 1'b1;
                        if (issue_cnt == len_m1) begin
                            state <= StDrain;
                            rd_en <= 1'b0;
                        end else begin
                            issue_cnt <= issue_cnt + 1'b1;
                        end
                    end
                end
                StDrain: begin
                    if (abort) begin
                        state   <= StFin;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        aborted <= 1'b1;
                        vpipe   <= '0;
                    end else if (vpipe_next == '0) begin
                        // Current cycle carries the last write-back (if any).
                        state <= StFin;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                StFin: begin
                    state     <= StIdle;
                    job_ready <= 1'b1;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pe_job_sequencer.sv
module tb_pe_job_sequencer;

    logic       clk;
    logic       rst;
    logic       job_valid;
    logic [3:0] job_base;
    logic [3:0] job_len_m1;
    logic       abort;
    logic       err1_in;
    logic       err2_in;

    logic       job_ready, rd_en, pe_en, wb_en, busy, done, aborted;
    logic [3:0] rd_addr, wb_addr;
    logic [7:0] err1_cnt, err2_cnt;

    // Second instance with a 2-bit error counter to exercise saturation.
    logic       job_ready2, rd_en2, pe_en2, wb_en2, busy2, done2, aborted2;
    logic [3:0] rd_addr2, wb_addr2;
    logic [1:0] err1_cnt2, err2_cnt2;

    int checks = 0;
    int errors = 0;

    pe_job_sequencer #(.DATA_NUM(16), .PIPE_LAT(3), .ECW(8)) dut (
        .clk(clk), .rst(rst), .job_valid(job_valid), .job_ready(job_ready),
        .job_base(job_base), .job_len_m1(job_len_m1), .abort(abort),
        .rd_en(rd_en), .rd_addr(rd_addr), .pe_en(pe_en), .wb_en(wb_en), .wb_addr(wb_addr),
        .err1_in(err1_in), .err2_in(err2_in), .err1_cnt(err1_cnt), .err2_cnt(err2_cnt),
        .busy(busy), .done(done), .aborted(aborted)
    );

    pe_job_sequencer #(.DATA_NUM(16), .PIPE_LAT(3), .ECW(2)) dut2 (
        .clk(clk), .rst(rst), .job_valid(job_valid), .job_ready(job_ready2),
        .job_base(job_base), .job_len_m1(job_len_m1), .abort(abort),
        .rd_en(rd_en2), .rd_addr(rd_addr2), .pe_en(pe_en2), .wb_en(wb_en2), .wb_addr(wb_addr2),
        .err1_in(err1_in), .err2_in(err2_in), .err1_cnt(err1_cnt2), .err2_cnt(err2_cnt2),
        .busy(busy2), .done(done2), .aborted(aborted2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] base;
        logic [3:0] len_m1;
        int e1;          // err1 high on cycles 2..e1+1
        int e2;          // err2 high on cycles 8..e2+7
        int abort_cyc;   // 0: no abort
        int exp_rd;
        int exp_wb;
        int exp_done;    // cycle of done, counted from accept edge
        int exp_busy;
        int exp_err1;
        int exp_err2;
        int exp_err1_s;  // ECW=2 instance
        int exp_aborted;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_job(input vec_t v);
        int rd_n, wb_n, busy_n, done_at, first_rd, first_wb;
        logic [3:0] ea;
        rd_n = 0; wb_n = 0; busy_n = 0; done_at = 0; first_rd = 0; first_wb = 0;
        job_base   = v.base;
        job_len_m1 = v.len_m1;
        job_valid  = 1'b1;
        step();
        job_valid = 1'b0;
        for (int cyc = 1; cyc <= 60 && done_at == 0; cyc++) begin
            if (rd_en) begin
                if (first_rd == 0) first_rd = cyc;
                ea = v.base + 4'(rd_n);
                chk("rd_addr", 32'(rd_addr), 32'(ea));
                rd_n++;
            end
            if (wb_en) begin
                if (first_wb == 0) first_wb = cyc;
                ea = v.base + 4'(wb_n);
                chk("wb_addr", 32'(wb_addr), 32'(ea));
                wb_n++;
            end
            if (busy) busy_n++;
            chk("pe_en", 32'(pe_en), 32'(cyc <= v.exp_busy));
            if (done) begin
                done_at = cyc;
                chk("aborted", 32'(aborted), 32'(v.exp_aborted));
                chk("err1_cnt", 32'(err1_cnt), 32'(v.exp_err1));
                chk("err2_cnt", 32'(err2_cnt), 32'(v.exp_err2));
                chk("err1_cnt_sat", 32'(err1_cnt2), 32'(v.exp_err1_s));
                chk("ready_in_fin", 32'(job_ready), 32'd0);
            end
            err1_in = (cyc >= 2) && (cyc < 2 + v.e1);
            err2_in = (cyc >= 8) && (cyc < 8 + v.e2);
            abort   = (cyc == v.abort_cyc);
            if (done_at == 0) step();
        end
        err1_in = 1'b0;
        err2_in = 1'b0;
        abort   = 1'b0;
        chk("done_cycle", 32'(done_at), 32'(v.exp_done));
        chk("rd_count", 32'(rd_n), 32'(v.exp_rd));
        chk("wb_count", 32'(wb_n), 32'(v.exp_wb));
        chk("busy_cycles", 32'(busy_n), 32'(v.exp_busy));
        if (v.exp_rd > 0) chk("first_rd_cycle", 32'(first_rd), 32'd1);
        if (v.exp_wb > 0) chk("first_wb_cycle", 32'(first_wb), 32'd4);
        step();
        chk("ready_after_fin", 32'(job_ready), 32'd1);
        chk("done_pulse_len", 32'(done), 32'd0);
        chk("err1_hold", 32'(err1_cnt), 32'(v.exp_err1));
    endtask

    initial begin
        //          base   len  e1 e2 ab  rd  wb  dn  bsy e1 e2 e1s ab
        vecs[0] = '{4'd0,  4'd3,  0, 0, 0,  4,  4,  8,  7, 0, 0, 0, 0};
        vecs[1] = '{4'd14, 4'd3,  0, 0, 0,  4,  4,  8,  7, 0, 0, 0, 0};
        vecs[2] = '{4'd5,  4'd15, 5, 2, 0, 16, 16, 20, 19, 5, 2, 3, 0};
        vecs[3] = '{4'd9,  4'd7,  0, 0, 3,  3,  0,  4,  3, 0, 0, 0, 1};
        vecs[4] = '{4'd3,  4'd0,  0, 0, 0,  1,  1,  5,  4, 0, 0, 0, 0};
        vecs[5] = '{4'd2,  4'd1,  0, 0, 4,  2,  1,  5,  4, 0, 0, 0, 1};

        rst = 1'b1; job_valid = 1'b0; job_base = '0; job_len_m1 = '0;
        abort = 1'b0; err1_in = 1'b0; err2_in = 1'b0;
        #12;
        chk("rst_ready", 32'(job_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rd_en", 32'(rd_en), 32'd0);
        chk("rst_wb_en", 32'(wb_en), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step();
        chk("idle_ready", 32'(job_ready), 32'd1);
        chk("idle_pe_en", 32'(pe_en), 32'd0);

        // Abort is ignored in IDLE.
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_idle_ready", 32'(job_ready), 32'd1);
        chk("abort_idle_done", 32'(done), 32'd0);

        for (int i = 0; i < 6; i++) run_job(vecs[i]);

        // job_valid held across two jobs: second accept right after FIN.
        job_base = 4'd4; job_len_m1 = 4'd1; job_valid = 1'b1;
        step();
        for (int cyc = 1; cyc <= 8; cyc++) begin
            if (cyc == 6) chk("b2b_done", 32'(done), 32'd1);
            if (cyc == 7) begin
                chk("b2b_ready", 32'(job_ready), 32'd1);
                chk("b2b_gap_rd", 32'(rd_en), 32'd0);
            end
            if (cyc == 8) begin
                chk("b2b_rd", 32'(rd_en), 32'd1);
                chk("b2b_rd_addr", 32'(rd_addr), 32'd4);
                chk("b2b_ready_low", 32'(job_ready), 32'd0);
                job_valid = 1'b0;
            end
            if (cyc < 8) step();
        end
        begin
            int seen;
            seen = 0;
            for (int k = 0; k < 30 && seen == 0; k++) begin
                step();
                if (done) seen = 1;
            end
            chk("b2b_second_done", 32'(seen), 32'd1);
            step();
        end

        // Asynchronous reset in DRAIN.
        job_base = 4'd7; job_len_m1 = 4'd3; job_valid = 1'b1;
        step();
        job_valid = 1'b0;
        for (int cyc = 1; cyc < 6; cyc++) step();
        chk("pre_rst_busy", 32'(busy), 32'd1);
        chk("pre_rst_rd_en", 32'(rd_en), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("async_ready", 32'(job_ready), 32'd1);
        chk("async_busy", 32'(busy), 32'd0);
        chk("async_wb_en", 32'(wb_en), 32'd0);
        chk("async_wb_addr", 32'(wb_addr), 32'd0);
        chk("async_rd_addr", 32'(rd_addr), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        begin
            int stray;
            stray = 0;
            for (int k = 0; k < 10; k++) begin
                step();
                if (done || busy || wb_en) stray++;
            end
            chk("no_done_after_rst", 32'(stray), 32'd0);
        end
        run_job('{4'd10, 4'd2, 0, 0, 0, 3, 3, 7, 6, 0, 0, 0, 0});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
